// File: rtl/emit_sched.sv
// Output scheduler sharing one link between priority and regular FIFOs; 1-cycle pop-to-valid latency.
// Priority wins until MaxBurst consecutive grants while regular waits; a stalled output register blocks all pops.
module emit_sched #(
    parameter int DataWidth = 32,
    parameter int MaxBurst  = 4,
    parameter int CntWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FifoPEmpty_i,
    input  logic [DataWidth-1:0] FifoPData_i,
    output logic                 FifoPRead_o,
    input  logic                 FifoREmpty_i,
    input  logic [DataWidth-1:0] FifoRData_i,
    output logic                 FifoRRead_o,
    output logic [DataWidth-1:0] Data_o,
    output logic                 Valid_o,
    input  logic                 Ready_i,
    output logic [CntWidth-1:0]  GrantP_o,
    output logic [CntWidth-1:0]  GrantR_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRIO = 2'd1,
        REG  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CntWidth-1:0]  burst_q, burst_d;
    logic [CntWidth-1:0]  grant_p_q, grant_p_d;
    logic [CntWidth-1:0]  grant_r_q, grant_r_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 slot_free;
    logic                 pop_p;
    logic                 pop_r;

    // Pop arbitration; reset masks the strobes so the FIFOs never lose a word while we flush.
    always_comb begin
        slot_free = !valid_q || Ready_i;
        pop_p     = 1'b0;
        pop_r     = 1'b0;
        if (!rst && slot_free) begin
            if (!FifoPEmpty_i && (FifoREmpty_i || (burst_q < CntWidth'(MaxBurst)))) begin
                pop_p = 1'b1;
            end else if (!FifoREmpty_i) begin
                pop_r = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        grant_p_d = grant_p_q;
        grant_r_d = grant_r_q;
        data_d    = data_q;
        valid_d   = valid_q;
        if (pop_p) begin
            data_d  = FifoPData_i;
            valid_d = 1'b1;
            state_d = PRIO;
            // Burst only accumulates while regular traffic is actually being held off.
            burst_d = FifoREmpty_i ? '0 : burst_q + 1'b1;
            if (grant_p_q != '1) begin
                grant_p_d = grant_p_q + 1'b1;
            end
        end else if (pop_r) begin
            data_d  = FifoRData_i;
            valid_d = 1'b1;
            state_d = REG;
            burst_d = '0;
            if (grant_r_q != '1) begin
                grant_r_d = grant_r_q + 1'b1;
            end
        end else if (valid_q && Ready_i) begin
            valid_d = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            grant_p_q <= '0;
            grant_r_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            grant_p_q <= grant_p_d;
            grant_r_q <= grant_r_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign FifoPRead_o = pop_p;
    assign FifoRRead_o = pop_r;
    assign Data_o      = data_q;
    assign Valid_o     = valid_q;
    assign GrantP_o    = grant_p_q;
    assign GrantR_o    = grant_r_q;

endmodule

// File: tb/tb_emit_sched.sv
// Scoreboard bench for emit_sched: queue-modelled FIFOs, reference arbiter, expected flits queued at pop time.
module tb_emit_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        pe, re, prd, rrd, vld, rdy;
    logic [31:0] pd, rd, dout;
    logic [7:0]  gp, gr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] pq[$];
    logic [31:0] rq[$];
    logic [31:0] exq[$];
    logic [31:0] got[$];

    logic        mvld;
    logic [7:0]  mburst, mgp, mgr;

    always #5 clk = ~clk;

    emit_sched #(.DataWidth(32), .MaxBurst(4), .CntWidth(8)) dut (
        .clk(clk), .rst(rst),
        .FifoPEmpty_i(pe), .FifoPData_i(pd), .FifoPRead_o(prd),
        .FifoREmpty_i(re), .FifoRData_i(rd), .FifoRRead_o(rrd),
        .Data_o(dout), .Valid_o(vld), .Ready_i(rdy),
        .GrantP_o(gp), .GrantR_o(gr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic ep, er, slot;
        pe = (pq.size() == 0);
        pd = pe ? 32'h0 : pq[0];
        re = (rq.size() == 0);
        rd = re ? 32'h0 : rq[0];
        #1;
        slot = !mvld || rdy;
        ep = !rst && slot && !pe && (re || (mburst < 8'd4));
        er = !rst && slot && !ep && !re;
        chk("rd_p", 32'(prd), 32'(ep));
        chk("rd_r", 32'(rrd), 32'(er));
        if (!rst) begin
            chk("valid", 32'(vld), 32'(mvld));
            chk("grant_p", 32'(gp), 32'(mgp));
            chk("grant_r", 32'(gr), 32'(mgr));
            if (mvld && rdy) begin
                got.push_back(dout);
                chk("sb_nonempty", 32'(exq.size() > 0), 32'd1);
                if (exq.size() > 0) begin
                    chk("data", dout, exq[0]);
                    exq.delete(0);
                end
            end
        end
        if (rst) begin
            mvld = 1'b0; mburst = 8'd0; mgp = 8'd0; mgr = 8'd0;
            exq.delete();
        end else if (ep) begin
            exq.push_back(pq.pop_front());
            mvld = 1'b1;
            mburst = re ? 8'd0 : mburst + 8'd1;
            if (mgp != 8'hFF) mgp = mgp + 8'd1;
        end else if (er) begin
            exq.push_back(rq.pop_front());
            mvld = 1'b1;
            mburst = 8'd0;
            if (mgr != 8'hFF) mgr = mgr + 8'd1;
        end else if (mvld && rdy) begin
            mvld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", 32'(vld), 32'd0);
        chk("rst_data", dout, 32'd0);
        chk("rst_gp", 32'(gp), 32'd0);
        chk("rst_gr", 32'(gr), 32'd0);
        got.delete();
    endtask

    initial begin
        logic [31:0] seq2 [8];
        rst = 1'b1; rdy = 1'b0;
        pe = 1'b1; re = 1'b1; pd = '0; rd = '0;
        mvld = 1'b0; mburst = '0; mgp = '0; mgr = '0;
        @(negedge clk);

        // Single priority flit
        do_reset();
        rdy = 1'b1;
        pq.push_back(32'hA000_0001);
        cycle();
        chk("t1_valid", 32'(vld), 32'd1);
        chk("t1_data", dout, 32'hA000_0001);
        chk("t1_gp", 32'(gp), 32'd1);
        run(3);
        chk("t1_drain", 32'(exq.size()), 32'd0);

        // Burst limit lets regular through after four priority grants
        do_reset();
        for (int i = 1; i <= 6; i++) pq.push_back(32'hB000_0000 + 32'(i));
        rq.push_back(32'hC000_0001);
        rq.push_back(32'hC000_0002);
        seq2 = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004,
                 32'hC000_0001, 32'hB000_0005, 32'hB000_0006, 32'hC000_0002};
        run(12);
        chk("t2_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk("t2_order", got[i], seq2[i]);
        end

        // Regular-only, back to back
        do_reset();
        for (int i = 1; i <= 3; i++) rq.push_back(32'hD000_0000 + 32'(i));
        run(3);
        chk("t3_gr", 32'(gr), 32'd3);
        chk("t3_valid", 32'(vld), 32'd1);
        chk("t3_last", dout, 32'hD000_0003);
        run(3);

        // Output stall holds data and blocks pops
        do_reset();
        rdy = 1'b0;
        pq.push_back(32'h1234_5678);
        pq.push_back(32'hE000_0002);
        rq.push_back(32'hF000_0001);
        cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_stall_data", dout, 32'h1234_5678);
        end
        rdy = 1'b1;
        cycle();
        chk("t4_next", dout, 32'hE000_0002);
        run(4);
        chk("t4_drain", 32'(exq.size()), 32'd0);

        // Reset mid-transfer with burst at its limit
        do_reset();
        for (int i = 1; i <= 10; i++) pq.push_back(32'h7000_0000 + 32'(i));
        rq.push_back(32'h8000_0001);
        rq.push_back(32'h8000_0002);
        run(4);
        chk("t5_pre_valid", 32'(vld), 32'd1);
        do_reset();
        cycle();
        chk("t5_resume", dout, 32'h7000_0005);
        run(16);
        chk("t5_drain", 32'(exq.size()), 32'd0);

        // Grant counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) pq.push_back(32'h6000_0000 + 32'(i));
        run(305);
        chk("t6_gp_sat", 32'(gp), 32'd255);
        chk("t6_gr", 32'(gr), 32'd0);
        chk("t6_count", 32'(got.size()), 32'd300);
        chk("t6_drain", 32'(exq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
